// File: rtl/msrv_32_store_queue_pkg.sv
// Shared encodings and types for the MSRV32 store path: AHB transfer types,
// store funct3 codes, bus FSM states and the default queue entry layout.
package msrv_32_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ADDR = 2'd1,
    BUS_DATA = 2'd2
  } bus_state_e;

  localparam logic [1:0] ST_IDLE = BUS_IDLE;
  localparam logic [1:0] ST_ADDR = BUS_ADDR;
  localparam logic [1:0] ST_DATA = BUS_DATA;

  localparam int SQ_XLEN   = 32;
  localparam int SQ_ADDR_W = 32;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_XLEN-1:0]   data;
    logic [SQ_XLEN/8-1:0] mask;
    logic [2:0]           hsize;
  } sq_entry_t;

endpackage

// File: rtl/msrv_32_store_queue_if.sv
// AHB-Lite write-side signals between the store queue (master) and the
// data-memory port (slave).
interface msrv_32_store_queue_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                ahb_ready_in;
  logic [ADDR_W-1:0]   ms_riscv32_mp_dmadder_out;
  logic [XLEN-1:0]     ms_riscv32_mp_dmdata_out;
  logic [XLEN/8-1:0]   ms_riscv32_mp_dmwr_mask_out;
  logic                ms_riscv32_mp_dmwr_req_out;
  logic [1:0]          ahb_htrans_out;
  logic [2:0]          ahb_hsize_out;

  modport master (
    input  ahb_ready_in,
    output ms_riscv32_mp_dmadder_out, ms_riscv32_mp_dmdata_out,
           ms_riscv32_mp_dmwr_mask_out, ms_riscv32_mp_dmwr_req_out,
           ahb_htrans_out, ahb_hsize_out
  );

  modport slave (
    output ahb_ready_in,
    input  ms_riscv32_mp_dmadder_out, ms_riscv32_mp_dmdata_out,
           ms_riscv32_mp_dmwr_mask_out, ms_riscv32_mp_dmwr_req_out,
           ahb_htrans_out, ahb_hsize_out
  );
endinterface

// File: rtl/msrv_32_store_queue_fifo.sv
// Generic DEPTH-entry FIFO with full/empty flags and every slot exposed in
// parallel (with a per-slot valid bit) so callers can search the contents.
module msrv_32_store_fifo
  import msrv_32_pkg::*;
#(
  parameter type entry_t = sq_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output entry_t           entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int             PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] ONE   = (PTR_W+1)'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;
  entry_t           mem_q [DEPTH];

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: slots are only observed through valid_o/head_o.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] rel;
    assign rel         = PTR_W'(gi) - rd_ptr_q;
    assign valid_o[gi] = ({1'b0, rel} < count_q);
  end

endmodule

// File: rtl/msrv_32_store_queue.sv
// Store path between execute and the AHB-Lite data port: lane-aligns stores,
// buffers them, drains them as pipelined NONSEQ writes and flags load hazards.
module msrv_32_store_queue
  import msrv_32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_in,
  input  logic [2:0]           funct3_in,
  input  logic [ADDR_W-1:0]    iaddr_in,
  input  logic [XLEN-1:0]      rs2_in,
  input  logic                 mem_wr_req_in,
  output logic                 st_ready_out,
  output logic                 misaligned_out,
  input  logic [ADDR_W-1:0]    ld_addr_in,
  output logic                 ld_hazard_out,
  output logic                 sq_empty_out,
  msrv_32_store_queue_if.master ahb
);
  localparam int                NB        = XLEN / 8;
  localparam int                OFF_W     = $clog2(NB);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(NB - 1);

  // Same field layout as sq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [NB-1:0]     mask;
    logic [2:0]        hsize;
  } entry_t;

  logic             bad_req;
  logic [OFF_W-1:0] off;
  logic [XLEN-1:0]  size_bits;
  logic [NB-1:0]    lane_bits;
  entry_t           push_entry, head, probe, probe_mask;
  entry_t           fifo_entries [DEPTH];
  logic [DEPTH-1:0] fifo_valid, ent_hit;
  logic             fifo_full, fifo_empty, push, pop, addr_phase;
  logic [1:0]       state_q, state_d;
  logic [ADDR_W-1:0] dp_addr_q;
  logic [XLEN-1:0]  dp_data_q;
  logic [NB-1:0]    dp_mask_q;

  always_comb begin
    case (funct3_in)
      F3_SB:   bad_req = 1'b0;
      F3_SH:   bad_req = iaddr_in[0];
      F3_SW:   bad_req = |iaddr_in[1:0];
      F3_SD:   bad_req = (XLEN == 32) || (|iaddr_in[2:0]);
      default: bad_req = 1'b1;
    endcase
  end

  assign misaligned_out = mem_wr_req_in && bad_req;
  assign st_ready_out   = !fifo_full;
  assign push           = mem_wr_req_in && !fifo_full && !bad_req;

  assign off = iaddr_in[OFF_W-1:0];

  always_comb begin
    case (funct3_in[1:0])
      2'b00:   begin size_bits = XLEN'(8'hFF);         lane_bits = NB'(1);  end
      2'b01:   begin size_bits = XLEN'(16'hFFFF);      lane_bits = NB'(3);  end
      2'b10:   begin size_bits = XLEN'(32'hFFFF_FFFF); lane_bits = NB'(15); end
      default: begin size_bits = '1;                   lane_bits = '1;      end
    endcase
  end

  // Masking before the shift keeps every lane outside the store at zero.
  always_comb begin
    push_entry.addr  = iaddr_in & LINE_MASK;
    push_entry.data  = (rs2_in & size_bits) << {off, 3'b000};
    push_entry.mask  = lane_bits << off;
    push_entry.hsize = {1'b0, funct3_in[1:0]};
  end

  msrv_32_store_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i       (ms_riscv32_mp_clk_in),
    .rst_ni      (ms_riscv32_mp_rst_in),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .entries_o   (fifo_entries),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_ADDR;
      ST_ADDR: if (ahb.ahb_ready_in) begin
        pop     = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: if (ahb.ahb_ready_in) begin
        if (!fifo_empty) pop = 1'b1;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q   <= ST_IDLE;
      dp_addr_q <= '0;
      dp_data_q <= '0;
      dp_mask_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        dp_addr_q <= head.addr;
        dp_data_q <= head.data;
        dp_mask_q <= head.mask;
      end
    end
  end

  // The head is only consumed on HREADY, so the presented address stays put
  // through wait states of the overlapping data phase.
  assign addr_phase = (state_q == ST_ADDR) || ((state_q == ST_DATA) && !fifo_empty);

  assign ahb.ahb_htrans_out              = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.ms_riscv32_mp_dmwr_req_out  = addr_phase;
  assign ahb.ms_riscv32_mp_dmadder_out   = addr_phase ? head.addr : '0;
  assign ahb.ahb_hsize_out               = addr_phase ? head.hsize : 3'b000;
  assign ahb.ms_riscv32_mp_dmdata_out    = (state_q == ST_DATA) ? dp_data_q : '0;
  assign ahb.ms_riscv32_mp_dmwr_mask_out = (state_q == ST_DATA) ? dp_mask_q : '0;

  assign sq_empty_out = fifo_empty && (state_q == ST_IDLE);

  always_comb begin
    probe           = '0;
    probe.addr      = ld_addr_in & LINE_MASK;
    probe_mask      = '0;
    probe_mask.addr = LINE_MASK;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign ent_hit[gi] = fifo_valid[gi] && ((fifo_entries[gi] & probe_mask) == probe);
  end

  assign ld_hazard_out = (|ent_hit) ||
                         ((state_q == ST_DATA) && (dp_addr_q == (ld_addr_in & LINE_MASK)));

endmodule
